// File: rtl/mem_ctrl_arbiter_pkg.sv
// Shared types for the memory-controller arbiter: block address/data, request type, read tag.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_ctrl_arbiter_pkg;

    localparam int MAIN_MEM_BLOCK_ADDR_W = 32;
    localparam int BLOCK_DATA_W          = 64;
    // Tag channel-id field is sized for up to 16 requesters.
    localparam int MEM_ARB_CH_ID_W       = 4;

    typedef logic [MAIN_MEM_BLOCK_ADDR_W-1:0] main_mem_block_addr_t;
    typedef logic [BLOCK_DATA_W-1:0]          block_data_t;

    typedef enum logic {
        REQ_READ  = 1'b0,
        REQ_WRITE = 1'b1
    } req_type_t;

    // One entry per outstanding read: who gets the response, and whether it is discarded.
    typedef struct packed {
        logic [MEM_ARB_CH_ID_W-1:0] ch_id;
        logic                       drop;
    } mem_arb_tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin selector: first eligible requester at or after ptr, wrapping modulo N.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the grant is consumed and moves ptr.
//
// Ports: eligible[N] request mask, ptr starting index (must be < N),
//        grant one-hot, grant_idx encoded winner, any = at least one eligible.
module rr_arbiter #(
    parameter int  N     = 2,
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     eligible,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             any
);

    always_comb begin : select
        // One extra bit so ptr + offset (< 2N) cannot overflow before the wrap.
        logic [IDX_W:0] idx;
        idx       = '0;
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        for (int off = 0; off < N; off++) begin
            idx = {1'b0, ptr} + (IDX_W+1)'(off);
            if (idx >= (IDX_W+1)'(N)) begin
                idx = idx - (IDX_W+1)'(N);
            end
            if (!any && eligible[idx[IDX_W-1:0]]) begin
                any                     = 1'b1;
                grant[idx[IDX_W-1:0]]   = 1'b1;
                grant_idx               = idx[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/mem_ctrl_arbiter.sv
// N-channel arbiter onto one memory-controller port; round-robin grant, in-order read-response routing with per-channel flush.
// Latency: request path and response path are both combinational (zero cycles); tracking state updates on the clock edge.
// Backpressure: mem_req_ready is passed to the granted channel only; reads stall while MAX_OUTSTANDING reads are in flight, writes never stall on that.
//
// Ports: clk/rst_aL; per-channel req_valid/req_type/req_block_addr/req_block_data -> req_ready;
//        flush[N_CH] discards that channel's in-flight reads; resp_valid (one-hot) + shared resp_block_data;
//        mem_req_* / mem_req_ready to the controller; mem_resp_valid/mem_resp_block_data back;
//        err_unexpected_resp sticky flag for a response with nothing outstanding.
module mem_ctrl_arbiter
    import mem_ctrl_arbiter_pkg::*;
#(
    parameter int  N_CH            = 2,  // up to 2**MEM_ARB_CH_ID_W requesters
    parameter int  MAX_OUTSTANDING = 4,  // power of 2, >= 2
    localparam int CH_ID_W         = $clog2(N_CH)
) (
    input  logic                                 clk,
    input  logic                                 rst_aL,

    input  logic                 [N_CH-1:0]      req_valid,
    input  req_type_t            [N_CH-1:0]      req_type,
    input  main_mem_block_addr_t [N_CH-1:0]      req_block_addr,
    input  block_data_t          [N_CH-1:0]      req_block_data,
    output logic                 [N_CH-1:0]      req_ready,
    input  logic                 [N_CH-1:0]      flush,
    output logic                 [N_CH-1:0]      resp_valid,
    output block_data_t                          resp_block_data,

    output logic                                 mem_req_valid,
    output req_type_t                            mem_req_type,
    output main_mem_block_addr_t                 mem_req_block_addr,
    output block_data_t                          mem_req_block_data,
    input  logic                                 mem_req_ready,
    input  logic                                 mem_resp_valid,
    input  block_data_t                          mem_resp_block_data,

    output logic                                 err_unexpected_resp
);

    localparam int PTR_W = $clog2(MAX_OUTSTANDING);
    localparam int CNT_W = PTR_W + 1;

    mem_arb_tag_t             tag_q [MAX_OUTSTANDING];
    logic [PTR_W-1:0]         head;
    logic [PTR_W-1:0]         tail;
    logic [CNT_W-1:0]         count;
    logic [CH_ID_W-1:0]       rr_ptr;
    logic                     err_q;

    logic                     fifo_full;
    logic                     fifo_empty;
    logic [N_CH-1:0]          eligible;
    logic [N_CH-1:0]          gnt_oh;
    logic [CH_ID_W-1:0]       gnt_idx;
    logic                     gnt_any;
    logic                     hs;
    logic                     push;
    logic                     pop;
    mem_arb_tag_t             head_tag;
    logic [MAX_OUTSTANDING-1:0] flush_hit;
    logic [N_CH-1:0]          resp_int;

    assign fifo_full  = (count == CNT_W'(MAX_OUTSTANDING));
    assign fifo_empty = (count == '0);

    // A full tracker blocks reads even when a response frees a slot this cycle,
    // which keeps eligibility independent of the response path.
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            eligible[i] = req_valid[i] && !flush[i] &&
                          ((req_type[i] == REQ_WRITE) || !fifo_full);
        end
    end

    rr_arbiter #(.N(N_CH)) u_rr_arbiter (
        .eligible  (eligible),
        .ptr       (rr_ptr),
        .grant     (gnt_oh),
        .grant_idx (gnt_idx),
        .any       (gnt_any)
    );

    assign hs       = gnt_any && mem_req_ready;
    assign push     = hs && (req_type[gnt_idx] == REQ_READ);
    assign pop      = mem_resp_valid && !fifo_empty;
    assign head_tag = tag_q[head];

    // Mark every live entry belonging to a flushed channel. Entry k is live when
    // its distance from head (mod depth) is below the occupancy count.
    always_comb begin : flush_match
        logic [PTR_W-1:0] off;
        logic             id_hit;
        off       = '0;
        id_hit    = 1'b0;
        flush_hit = '0;
        for (int k = 0; k < MAX_OUTSTANDING; k++) begin
            off    = PTR_W'(k) - head;
            id_hit = 1'b0;
            for (int i = 0; i < N_CH; i++) begin
                if (flush[i] && (tag_q[k].ch_id == MEM_ARB_CH_ID_W'(i))) begin
                    id_hit = 1'b1;
                end
            end
            flush_hit[k] = id_hit && ({1'b0, off} < count);
        end
    end

    // A flush landing on the head in the same cycle as its response drops it too.
    always_comb begin
        resp_int = '0;
        if (pop && !head_tag.drop && !flush_hit[head]) begin
            for (int i = 0; i < N_CH; i++) begin
                if (head_tag.ch_id == MEM_ARB_CH_ID_W'(i)) begin
                    resp_int[i] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_aL) begin
        if (!rst_aL) begin
            head   <= '0;
            tail   <= '0;
            count  <= '0;
            rr_ptr <= '0;
            err_q  <= 1'b0;
            for (int k = 0; k < MAX_OUTSTANDING; k++) begin
                tag_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < MAX_OUTSTANDING; k++) begin
                if (flush_hit[k]) begin
                    tag_q[k].drop <= 1'b1;
                end
            end
            // The tail slot is never live on a push, so it cannot collide with a flush mark.
            if (push) begin
                tag_q[tail] <= '{ch_id: MEM_ARB_CH_ID_W'(gnt_idx), drop: 1'b0};
                tail        <= tail + PTR_W'(1);
            end
            if (pop) begin
                head <= head + PTR_W'(1);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (!push && pop) begin
                count <= count - CNT_W'(1);
            end
            if (hs) begin
                rr_ptr <= (gnt_idx == CH_ID_W'(N_CH - 1)) ? '0 : gnt_idx + CH_ID_W'(1);
            end
            if (mem_resp_valid && fifo_empty) begin
                err_q <= 1'b1;
            end
        end
    end

    // Outputs are forced low while reset is held, including the combinational paths.
    assign mem_req_valid       = rst_aL && gnt_any;
    assign mem_req_type        = rst_aL ? req_type[gnt_idx] : REQ_READ;
    assign mem_req_block_addr  = rst_aL ? req_block_addr[gnt_idx] : '0;
    assign mem_req_block_data  = rst_aL ? req_block_data[gnt_idx] : '0;
    assign req_ready           = (rst_aL && mem_req_ready) ? gnt_oh : '0;
    assign resp_valid          = rst_aL ? resp_int : '0;
    assign resp_block_data     = rst_aL ? mem_resp_block_data : '0;
    assign err_unexpected_resp = rst_aL && err_q;

endmodule

// File: tb/tb_mem_ctrl_arbiter.sv
// Bench for mem_ctrl_arbiter with a queue-based reference model of outstanding reads.
// Latency: inputs driven on the falling edge, outputs sampled 1 time unit later.
// Backpressure: mem_req_ready and response timing are driven by directed and random stimulus.
module tb_mem_ctrl_arbiter;
    import mem_ctrl_arbiter_pkg::*;

    localparam int N_CH    = 2;
    localparam int MAX_OUT = 4;

    logic                                  clk = 1'b0;
    logic                                  rst_aL;
    logic                 [N_CH-1:0]       req_valid;
    req_type_t            [N_CH-1:0]       req_type;
    main_mem_block_addr_t [N_CH-1:0]       req_block_addr;
    block_data_t          [N_CH-1:0]       req_block_data;
    logic                 [N_CH-1:0]       req_ready;
    logic                 [N_CH-1:0]       flush;
    logic                 [N_CH-1:0]       resp_valid;
    block_data_t                           resp_block_data;
    logic                                  mem_req_valid;
    req_type_t                             mem_req_type;
    main_mem_block_addr_t                  mem_req_block_addr;
    block_data_t                           mem_req_block_data;
    logic                                  mem_req_ready;
    logic                                  mem_resp_valid;
    block_data_t                           mem_resp_block_data;
    logic                                  err_unexpected_resp;

    always #5 clk = ~clk;

    mem_ctrl_arbiter #(.N_CH(N_CH), .MAX_OUTSTANDING(MAX_OUT)) dut (
        .clk                 (clk),
        .rst_aL              (rst_aL),
        .req_valid           (req_valid),
        .req_type            (req_type),
        .req_block_addr      (req_block_addr),
        .req_block_data      (req_block_data),
        .req_ready           (req_ready),
        .flush               (flush),
        .resp_valid          (resp_valid),
        .resp_block_data     (resp_block_data),
        .mem_req_valid       (mem_req_valid),
        .mem_req_type        (mem_req_type),
        .mem_req_block_addr  (mem_req_block_addr),
        .mem_req_block_data  (mem_req_block_data),
        .mem_req_ready       (mem_req_ready),
        .mem_resp_valid      (mem_resp_valid),
        .mem_resp_block_data (mem_resp_block_data),
        .err_unexpected_resp (err_unexpected_resp)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: next-preferred channel, list of outstanding reads in issue order.
    int  m_rr;
    int  q_ch[$];
    bit  q_drop[$];
    bit  m_err;

    // Expectations for the current input set.
    bit              e_any;
    int              e_g;
    logic [N_CH-1:0] e_req_ready;
    logic [N_CH-1:0] e_resp_valid;

    task automatic model_reset();
        m_rr  = 0;
        m_err = 0;
        q_ch.delete();
        q_drop.delete();
    endtask

    task automatic predict();
        int idx;
        e_any        = 0;
        e_g          = 0;
        e_req_ready  = '0;
        e_resp_valid = '0;
        for (int off = 0; off < N_CH; off++) begin
            idx = (m_rr + off) % N_CH;
            if (!e_any && req_valid[idx] && !flush[idx] &&
                (req_type[idx] == REQ_WRITE || q_ch.size() < MAX_OUT)) begin
                e_any = 1;
                e_g   = idx;
            end
        end
        if (e_any && mem_req_ready) e_req_ready[e_g] = 1'b1;
        if (mem_resp_valid && q_ch.size() > 0 && !q_drop[0] && !flush[q_ch[0]])
            e_resp_valid[q_ch[0]] = 1'b1;
    endtask

    // Apply this cycle's effects to the model, then advance to the next falling edge.
    task automatic tick();
        predict();
        for (int k = 0; k < q_ch.size(); k++) begin
            if (flush[q_ch[k]]) q_drop[k] = 1;
        end
        if (mem_resp_valid) begin
            if (q_ch.size() == 0) begin
                m_err = 1;
            end else begin
                void'(q_ch.pop_front());
                void'(q_drop.pop_front());
            end
        end
        if (e_any && mem_req_ready) begin
            if (req_type[e_g] == REQ_READ) begin
                q_ch.push_back(e_g);
                q_drop.push_back(1'b0);
            end
            m_rr = (e_g + 1) % N_CH;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        req_valid           = '0;
        flush               = '0;
        mem_req_ready       = 1'b1;
        mem_resp_valid      = 1'b0;
        mem_resp_block_data = '0;
        for (int i = 0; i < N_CH; i++) begin
            req_type[i]       = REQ_READ;
            req_block_addr[i] = '0;
            req_block_data[i] = '0;
        end
    endtask

    task automatic test_reset();
        rst_aL = 1'b0;
        idle();
        req_valid           = 2'b11;
        req_block_addr[0]   = 32'h10;
        req_block_addr[1]   = 32'h20;
        mem_resp_valid      = 1'b1;
        mem_resp_block_data = 64'hDEAD_BEEF_0000_0001;
        #2;
        checks++;
        if (mem_req_valid !== 1'b0) begin failures++; $display("FAIL reset_mem_req_valid got=%b want=0", mem_req_valid); end
        checks++;
        if (req_ready !== 2'b00) begin failures++; $display("FAIL reset_req_ready got=%b want=00", req_ready); end
        checks++;
        if (resp_valid !== 2'b00) begin failures++; $display("FAIL reset_resp_valid got=%b want=00", resp_valid); end
        checks++;
        if (err_unexpected_resp !== 1'b0) begin failures++; $display("FAIL reset_err got=%b want=0", err_unexpected_resp); end
        checks++;
        if (mem_req_block_addr !== '0) begin failures++; $display("FAIL reset_mem_addr got=%h want=0", mem_req_block_addr); end
        @(negedge clk);
        idle();
        rst_aL = 1'b1;
        model_reset();
    endtask

    task automatic test_contention();
        block_data_t d [4];
        logic [N_CH-1:0] want;
        req_type[0] = REQ_READ;        req_type[1] = REQ_READ;
        req_block_addr[0] = 32'h10;    req_block_addr[1] = 32'h20;
        req_valid = 2'b11;
        for (int c = 0; c < 4; c++) begin
            #1;
            want = (c % 2 == 0) ? 2'b01 : 2'b10;
            checks++;
            if (req_ready !== want) begin failures++; $display("FAIL contention_grant%0d got=%b want=%b", c, req_ready, want); end
            checks++;
            if (mem_req_block_addr !== ((c % 2 == 0) ? 32'h10 : 32'h20))
                begin failures++; $display("FAIL contention_addr%0d got=%h", c, mem_req_block_addr); end
            tick();
        end
        req_valid = '0;
        for (int c = 0; c < 4; c++) begin
            d[c] = {$urandom, $urandom};
            mem_resp_valid      = 1'b1;
            mem_resp_block_data = d[c];
            #1;
            want = (c % 2 == 0) ? 2'b01 : 2'b10;
            checks++;
            if (resp_valid !== want) begin failures++; $display("FAIL contention_resp%0d got=%b want=%b", c, resp_valid, want); end
            checks++;
            if (resp_block_data !== d[c]) begin failures++; $display("FAIL contention_data%0d got=%h want=%h", c, resp_block_data, d[c]); end
            tick();
        end
        idle();
    endtask

    task automatic test_full();
        req_type[0] = REQ_READ;
        req_valid   = 2'b01;
        for (int c = 0; c < 4; c++) begin
            req_block_addr[0] = $urandom;
            #1;
            checks++;
            if (req_ready !== 2'b01) begin failures++; $display("FAIL full_fill%0d got=%b want=01", c, req_ready); end
            tick();
        end
        // Fifth read held; a write from ch1 still goes through.
        req_block_addr[0] = 32'h55;
        req_type[1]       = REQ_WRITE;
        req_block_addr[1] = 32'h77;
        req_block_data[1] = 64'h1234;
        req_valid         = 2'b11;
        #1;
        checks++;
        if (req_ready !== 2'b10) begin failures++; $display("FAIL full_write_pass got=%b want=10", req_ready); end
        checks++;
        if (mem_req_type !== REQ_WRITE) begin failures++; $display("FAIL full_write_type got=%b want=1", mem_req_type); end
        tick();
        // Response frees a slot, but the read still waits this cycle.
        req_valid           = 2'b01;
        mem_resp_valid      = 1'b1;
        mem_resp_block_data = 64'hAAAA;
        #1;
        checks++;
        if (req_ready !== 2'b00 || mem_req_valid !== 1'b0)
            begin failures++; $display("FAIL full_pop_same_cycle got ready=%b valid=%b want 00/0", req_ready, mem_req_valid); end
        checks++;
        if (resp_valid !== 2'b01) begin failures++; $display("FAIL full_resp got=%b want=01", resp_valid); end
        tick();
        mem_resp_valid = 1'b0;
        #1;
        checks++;
        if (req_ready !== 2'b01) begin failures++; $display("FAIL full_next_accept got=%b want=01", req_ready); end
        tick();
        req_valid = '0;
        for (int c = 0; c < 4; c++) begin
            mem_resp_valid      = 1'b1;
            mem_resp_block_data = {$urandom, $urandom};
            #1;
            checks++;
            if (resp_valid !== 2'b01) begin failures++; $display("FAIL full_drain%0d got=%b want=01", c, resp_valid); end
            tick();
        end
        idle();
    endtask

    task automatic test_flush();
        logic [N_CH-1:0] want;
        req_valid = 2'b01;
        tick();
        req_valid = 2'b10;
        tick();
        tick();
        req_valid = '0;
        flush     = 2'b10;
        tick();
        flush = '0;
        for (int c = 0; c < 3; c++) begin
            mem_resp_valid      = 1'b1;
            mem_resp_block_data = {$urandom, $urandom};
            #1;
            want = (c == 0) ? 2'b01 : 2'b00;
            checks++;
            if (resp_valid !== want) begin failures++; $display("FAIL flush_resp%0d got=%b want=%b", c, resp_valid, want); end
            tick();
        end
        mem_resp_valid = 1'b0;
        // Tracker must be empty again: four reads fit back to back.
        req_valid = 2'b10;
        for (int c = 0; c < 4; c++) begin
            #1;
            checks++;
            if (req_ready !== 2'b10) begin failures++; $display("FAIL flush_empty_refill%0d got=%b want=10", c, req_ready); end
            tick();
        end
        req_valid = '0;
        for (int c = 0; c < 4; c++) begin
            mem_resp_valid = 1'b1;
            tick();
        end
        idle();
    endtask

    task automatic test_flush_on_pop();
        req_valid = 2'b01;
        tick();
        flush               = 2'b01;
        mem_resp_valid      = 1'b1;
        mem_resp_block_data = 64'h5A5A;
        #1;
        checks++;
        if (resp_valid !== 2'b00) begin failures++; $display("FAIL flush_pop_resp got=%b want=00", resp_valid); end
        checks++;
        if (req_ready !== 2'b00 || mem_req_valid !== 1'b0)
            begin failures++; $display("FAIL flush_pop_nogrant ready=%b valid=%b want 00/0", req_ready, mem_req_valid); end
        tick();
        flush          = '0;
        mem_resp_valid = 1'b0;
        tick();
        req_valid = '0;
        mem_resp_valid = 1'b1;
        #1;
        checks++;
        if (resp_valid !== 2'b01) begin failures++; $display("FAIL flush_pop_entry_gone got=%b want=01", resp_valid); end
        tick();
        idle();
    endtask

    task automatic test_backpressure();
        int rr0;
        rr0 = m_rr;
        req_type[0] = REQ_WRITE;     req_type[1] = REQ_WRITE;
        req_block_addr[0] = 32'hA0;  req_block_addr[1] = 32'hB0;
        req_valid     = 2'b11;
        mem_req_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if (req_ready !== 2'b00 || mem_req_valid !== 1'b1)
                begin failures++; $display("FAIL bp_stall%0d ready=%b valid=%b want 00/1", c, req_ready, mem_req_valid); end
            checks++;
            if (mem_req_block_addr !== req_block_addr[rr0])
                begin failures++; $display("FAIL bp_addr%0d got=%h want=%h", c, mem_req_block_addr, req_block_addr[rr0]); end
            tick();
        end
        mem_req_ready = 1'b1;
        #1;
        checks++;
        if (req_ready !== (2'b01 << rr0)) begin failures++; $display("FAIL bp_release got=%b want=%b", req_ready, 2'b01 << rr0); end
        tick();
        idle();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N_CH; i++) begin
                if (!req_valid[i] || e_req_ready[i]) begin
                    req_valid[i]      = ($urandom_range(0, 9) < 6);
                    req_type[i]       = req_type_t'($urandom_range(0, 1));
                    req_block_addr[i] = $urandom;
                    req_block_data[i] = {$urandom, $urandom};
                end
                flush[i] = ($urandom_range(0, 9) == 0);
            end
            mem_req_ready       = ($urandom_range(0, 3) != 0);
            mem_resp_valid      = (q_ch.size() > 0) && ($urandom_range(0, 1) == 1);
            mem_resp_block_data = {$urandom, $urandom};
            #1;
            predict();
            checks++;
            if (req_ready !== e_req_ready) begin failures++; $display("FAIL rnd%0d req_ready got=%b want=%b", c, req_ready, e_req_ready); end
            checks++;
            if (mem_req_valid !== e_any) begin failures++; $display("FAIL rnd%0d mem_req_valid got=%b want=%b", c, mem_req_valid, e_any); end
            checks++;
            if (resp_valid !== e_resp_valid) begin failures++; $display("FAIL rnd%0d resp_valid got=%b want=%b", c, resp_valid, e_resp_valid); end
            checks++;
            if (err_unexpected_resp !== m_err) begin failures++; $display("FAIL rnd%0d err got=%b want=%b", c, err_unexpected_resp, m_err); end
            if (e_any) begin
                checks++;
                if (mem_req_type !== req_type[e_g] || mem_req_block_addr !== req_block_addr[e_g] ||
                    mem_req_block_data !== req_block_data[e_g])
                    begin failures++; $display("FAIL rnd%0d mem_req_fields got=%b/%h/%h want ch%0d", c, mem_req_type, mem_req_block_addr, mem_req_block_data, e_g); end
            end
            if (e_resp_valid != '0) begin
                checks++;
                if (resp_block_data !== mem_resp_block_data)
                    begin failures++; $display("FAIL rnd%0d resp_data got=%h want=%h", c, resp_block_data, mem_resp_block_data); end
            end
            tick();
        end
        idle();
    endtask

    task automatic test_error_reset();
        while (q_ch.size() > 0) begin
            mem_resp_valid = 1'b1;
            tick();
        end
        mem_resp_valid = 1'b1;
        #1;
        checks++;
        if (resp_valid !== 2'b00 || err_unexpected_resp !== 1'b0)
            begin failures++; $display("FAIL err_pre resp=%b err=%b want 00/0", resp_valid, err_unexpected_resp); end
        tick();
        mem_resp_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if (err_unexpected_resp !== 1'b1) begin failures++; $display("FAIL err_sticky%0d got=%b want=1", c, err_unexpected_resp); end
            tick();
        end
        req_valid = 2'b01;
        for (int c = 0; c < 3; c++) tick();
        req_valid      = 2'b11;
        mem_resp_valid = 1'b1;
        #1;
        rst_aL = 1'b0;
        #1;
        model_reset();
        checks++;
        if (err_unexpected_resp !== 1'b0 || mem_req_valid !== 1'b0 || req_ready !== 2'b00 || resp_valid !== 2'b00)
            begin failures++; $display("FAIL async_reset err=%b mvalid=%b ready=%b resp=%b want all 0", err_unexpected_resp, mem_req_valid, req_ready, resp_valid); end
        @(negedge clk);
        idle();
        rst_aL = 1'b1;
        mem_resp_valid = 1'b1;
        #1;
        checks++;
        if (resp_valid !== 2'b00) begin failures++; $display("FAIL reset_cleared_tracker got=%b want=00", resp_valid); end
        tick();
        mem_resp_valid = 1'b0;
        #1;
        checks++;
        if (err_unexpected_resp !== 1'b1) begin failures++; $display("FAIL err_after_reset got=%b want=1", err_unexpected_resp); end
    endtask

    initial begin
        test_reset();
        test_contention();
        test_full();
        test_flush();
        test_flush_on_pop();
        test_backpressure();
        test_random();
        test_error_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1);
    end

endmodule
